// File: rtl/prn_despread_rx.sv
// PRN despreading receiver: chip correlator with acquisition/lock tracking.
// Completed windows report correlation, slip requests and data bits.
module prn_despread_rx #(
   parameter int DIN_WIDTH = 16,
   parameter int SF        = 16,
   parameter int THRESH    = 2000,
   parameter int MISS_MAX  = 3
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  en,
   input  logic [DIN_WIDTH-1:0]                  rx_din,
   input  logic                                  rx_vld,
   input  logic                                  prn_chip,
   output logic                                  prn_slip,
   output logic [DIN_WIDTH+$clog2(SF):0]         corr_out,
   output logic                                  corr_vld,
   output logic                                  bit_out,
   output logic                                  bit_vld,
   output logic                                  locked,
   output logic [1:0]                            state
);

   localparam int LOG_SF = $clog2(SF);
   localparam int ACC_W  = DIN_WIDTH + LOG_SF + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ACQ  = 2'd1;
   localparam logic [1:0] S_LOCK = 2'd2;

   localparam logic [LOG_SF-1:0] CNT_LAST = LOG_SF'(SF - 1);
   localparam logic [3:0]        MISS_LIM = 4'(MISS_MAX);
   localparam logic [63:0]       THR      = 64'(THRESH);

   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  ext;
   logic [ACC_W-1:0]  prod;
   logic [ACC_W-1:0]  sum;
   logic [ACC_W-1:0]  mag;
   logic [LOG_SF-1:0] cnt;
   logic [3:0]        miss;
   logic [3:0]        miss_inc;
   logic              take;
   logic              last;
   logic              hit;

   assign ext  = {{(ACC_W-DIN_WIDTH){rx_din[DIN_WIDTH-1]}}, rx_din};
   assign prod = prn_chip ? ext : -ext;
   assign sum  = acc + prod;

   // ACC_W leaves headroom, so |sum| never overflows the magnitude.
   assign mag = sum[ACC_W-1] ? -sum : sum;
   assign hit = {{(64-ACC_W){1'b0}}, mag} >= THR;

   assign take     = en && rx_vld && (state != S_IDLE);
   assign last     = take && (cnt == CNT_LAST);
   assign miss_inc = miss + 4'd1;
   assign locked   = (state == S_LOCK);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         acc      <= '0;
         cnt      <= '0;
         miss     <= '0;
         corr_out <= '0;
         corr_vld <= 1'b0;
         bit_out  <= 1'b0;
         bit_vld  <= 1'b0;
         prn_slip <= 1'b0;
      end else begin
         corr_vld <= 1'b0;
         bit_vld  <= 1'b0;
         prn_slip <= 1'b0;
         if (!en || state == 2'd3) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            miss  <= '0;
         end else if (state == S_IDLE) begin
            state <= S_ACQ;
            acc   <= '0;
            cnt   <= '0;
            miss  <= '0;
         end else if (last) begin
            acc      <= '0;
            cnt      <= '0;
            corr_out <= sum;
            corr_vld <= 1'b1;
            if (state == S_ACQ) begin
               if (hit && miss == 4'd0) state <= S_LOCK;
               else prn_slip <= 1'b1;
            end else begin
               bit_vld <= 1'b1;
               bit_out <= ~sum[ACC_W-1];
               if (hit) begin
                  miss <= '0;
               end else if (miss_inc >= MISS_LIM) begin
                  miss  <= '0;
                  state <= S_ACQ;
               end else begin
                  miss <= miss_inc;
               end
            end
         end else if (take) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prn_despread_rx.sv
// Directed bench for prn_despread_rx at SF=16, THRESH=2000, MISS_MAX=3.
// Inputs and samples are taken on the falling clock edge.
module tb_prn_despread_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] rx_din;
   logic        rx_vld;
   logic        prn_chip;
   logic        prn_slip;
   logic [20:0] corr_out;
   logic        corr_vld;
   logic        bit_out;
   logic        bit_vld;
   logic        locked;
   logic [1:0]  state;

   int checks = 0;
   int errors = 0;

   prn_despread_rx #(
      .DIN_WIDTH(16),
      .SF(16),
      .THRESH(2000),
      .MISS_MAX(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .rx_din(rx_din),
      .rx_vld(rx_vld),
      .prn_chip(prn_chip),
      .prn_slip(prn_slip),
      .corr_out(corr_out),
      .corr_vld(corr_vld),
      .bit_out(bit_out),
      .bit_vld(bit_vld),
      .locked(locked),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs),
                $signed(exp));
      end
   endtask

   function automatic logic [31:0] corr_s();
      return 32'($signed(corr_out));
   endfunction

   task automatic feed(input logic [15:0] d, input logic p);
      rx_din   = d;
      prn_chip = p;
      rx_vld   = 1'b1;
      @(negedge clk);
      rx_vld   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic window(input string tag, input logic [15:0] d,
                         input logic p);
      for (int i = 0; i < 15; i++) feed(d, p);
      chk({tag, "_early_vld"}, 32'(corr_vld), 32'd0);
      feed(d, p);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rx_din = '0; rx_vld = 1'b0; prn_chip = 1'b0;
      idle(2);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_corr", corr_s(), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_pulses", {29'd0, corr_vld, bit_vld, prn_slip}, 32'd0);
      rst = 1'b0;
      en  = 1'b1;
      idle(1);
      chk("enter_acq", 32'(state), 32'd1);

      // acquisition on +200 then a data window of -200
      window("acq", 16'd200, 1'b1);
      chk("acq_vld", 32'(corr_vld), 32'd1);
      chk("acq_corr", corr_s(), 32'd3200);
      chk("acq_state", 32'(state), 32'd2);
      chk("acq_locked", 32'(locked), 32'd1);
      chk("acq_nobit", {30'd0, bit_vld, prn_slip}, 32'd0);
      idle(1);
      chk("vld_single", 32'(corr_vld), 32'd0);
      window("data", 16'hFF38, 1'b1);
      chk("data_corr", corr_s(), -32'sd3200);
      chk("data_bitvld", 32'(bit_vld), 32'd1);
      chk("data_bit", 32'(bit_out), 32'd0);
      idle(1);
      chk("bitvld_single", 32'(bit_vld), 32'd0);

      // three zero windows lose lock
      window("loss1", 16'd0, 1'b1);
      chk("loss1_bit", {30'd0, bit_vld, bit_out}, 32'd3);
      chk("loss1_state", 32'(state), 32'd2);
      window("loss2", 16'd0, 1'b1);
      chk("loss2_state", 32'(state), 32'd2);
      window("loss3", 16'd0, 1'b1);
      chk("loss3_bitvld", 32'(bit_vld), 32'd1);
      chk("loss3_state", 32'(state), 32'd1);
      chk("loss3_locked", 32'(locked), 32'd0);

      // misaligned window in ACQ requests a slip
      for (int i = 0; i < 16; i++)
         feed((i % 2 == 0) ? 16'd200 : 16'hFF38, 1'b1);
      chk("mis_vld", 32'(corr_vld), 32'd1);
      chk("mis_corr", corr_s(), 32'd0);
      chk("mis_slip", 32'(prn_slip), 32'd1);
      chk("mis_state", 32'(state), 32'd1);
      chk("mis_nobit", 32'(bit_vld), 32'd0);
      idle(1);
      chk("slip_single", 32'(prn_slip), 32'd0);

      // rx_vld gap inside a window
      for (int i = 0; i < 7; i++) feed(16'd200, 1'b1);
      idle(5);
      for (int i = 0; i < 8; i++) feed(16'd200, 1'b1);
      chk("gap_early", 32'(corr_vld), 32'd0);
      feed(16'd200, 1'b1);
      chk("gap_vld", 32'(corr_vld), 32'd1);
      chk("gap_corr", corr_s(), 32'd3200);
      chk("gap_state", 32'(state), 32'd2);

      // async reset mid-window
      for (int i = 0; i < 5; i++) feed(16'd200, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_corr", corr_s(), 32'd0);
      chk("arst_out", {29'd0, locked, bit_out, corr_vld}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      chk("arst_acq", 32'(state), 32'd1);
      window("fresh", 16'd200, 1'b1);
      chk("fresh_corr", corr_s(), 32'd3200);
      chk("fresh_state", 32'(state), 32'd2);

      // enable drop mid-window
      for (int i = 0; i < 7; i++) feed(16'd200, 1'b1);
      en = 1'b0;
      idle(1);
      chk("endrop_state", 32'(state), 32'd0);
      chk("endrop_locked", 32'(locked), 32'd0);
      chk("endrop_hold", corr_s(), 32'd3200);
      en = 1'b1;
      idle(1);
      chk("reen_state", 32'(state), 32'd1);

      // extreme samples, both as hits
      window("xpos", 16'h8000, 1'b0);
      chk("xpos_corr", corr_s(), 32'd524288);
      chk("xpos_state", 32'(state), 32'd2);
      chk("xpos_nobit", 32'(bit_vld), 32'd0);
      window("xneg", 16'h8000, 1'b1);
      chk("xneg_corr", corr_s(), -32'sd524288);
      chk("xneg_bit", {30'd0, bit_vld, bit_out}, 32'd2);
      window("xz1", 16'd0, 1'b1);
      window("xz2", 16'd0, 1'b1);
      chk("xneg_hit", 32'(state), 32'd2);

      // en falls while a result is being reported
      window("late", 16'd0, 1'b1);
      en = 1'b0;
      chk("late_vld", 32'(corr_vld), 32'd1);
      chk("late_bitvld", 32'(bit_vld), 32'd1);
      idle(1);
      chk("late_idle", 32'(state), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prn_despread_rx.md
PRN_DESPREAD_RX -- requirements
Module: prn_despread_rx

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 16, signed width of received chip samples.
REQ-002 SHALL have parameter SF, default 16, chips per symbol window; power of two, 4..256.
REQ-003 SHALL have parameter THRESH, default 2000, unsigned lock threshold on |correlation|.
REQ-004 SHALL have parameter MISS_MAX, default 3, consecutive below-threshold windows that drop lock; 1..15.
REQ-005 SHALL define ACC_W = DIN_WIDTH + log2(SF) + 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, receiver enable; low forces IDLE.
REQ-009 SHALL have port rx_din, input, DIN_WIDTH, signed received chip sample.
REQ-010 SHALL have port rx_vld, input, 1, rx_din and prn_chip valid this cycle.
REQ-011 SHALL have port prn_chip, input, 1, local M-sequence chip; 1 = +1, 0 = -1.
REQ-012 SHALL have port prn_slip, output, 1, one-cycle pulse asking the local PRN generator to hold one chip.
REQ-013 SHALL have port corr_out, output, ACC_W, signed correlation of the last completed window.
REQ-014 SHALL have port corr_vld, output, 1, one-cycle pulse marking a new corr_out.
REQ-015 SHALL have port bit_out, output, 1, despread data bit.
REQ-016 SHALL have port bit_vld, output, 1, one-cycle pulse marking a new bit_out.
REQ-017 SHALL have port locked, output, 1, high while state is LOCK.
REQ-018 SHALL have port state, output, 2, IDLE=0, ACQ=1, LOCK=2; 3 unused.

Function
REQ-019 SHALL accept a chip only on a cycle with rx_vld=1, en=1 and state not IDLE; cycles with rx_vld=0 leave accumulator and chip counter unchanged.
REQ-020 SHALL form the product as rx_din sign-extended to ACC_W when prn_chip=1, and its two's-complement negation when prn_chip=0; no saturation is needed because ACC_W guarantees no overflow.
REQ-021 SHALL keep a chip counter 0..SF-1; on accepting chip SF-1, register corr_out = acc + product, clear acc and counter, and assert corr_vld on the following cycle for exactly one cycle.
REQ-022 SHALL compute |corr| over ACC_W bits and compare it unsigned as |corr| >= THRESH, called a hit.
REQ-023 SHALL move IDLE->ACQ on the first cycle en=1, and any state->IDLE on the cycle after en=0; IDLE clears acc, chip counter and miss counter, and holds corr_out and bit_out.
REQ-024 ACQ SHALL, on window completion, go to LOCK on a hit with miss counter 0; otherwise it stays in ACQ and asserts prn_slip coincident with corr_vld.
REQ-025 LOCK SHALL, on window completion, assert bit_vld coincident with corr_vld, with bit_out = 1 if corr >= 0, else 0.
REQ-026 LOCK SHALL clear the miss counter on a hit and increment it on a miss; when it reaches MISS_MAX it SHALL go to ACQ with miss counter 0, and that final window still produces bit_vld.
REQ-027 SHALL NOT assert bit_vld for the window whose completion causes ACQ->LOCK.
REQ-028 A state change SHALL take effect on the same cycle corr_vld asserts; prn_slip, corr_vld and bit_vld SHALL never be high for more than one consecutive cycle.
REQ-029 When en falls on the same cycle a window completes, the window result SHALL still be reported; the state then goes to IDLE.

Reset
REQ-030 rst high SHALL asynchronously force state=IDLE and clear acc, chip counter, miss counter, corr_out, corr_vld, bit_out, bit_vld, prn_slip and locked to 0.
REQ-031 Release of rst SHALL be synchronous to clk; the first chip is accepted no earlier than the cycle after release with en=1.

Verification
REQ-032 Reset (SF=16, THRESH=2000, MISS_MAX=3): assert rst mid-window -> all outputs 0 immediately; state=0; a subsequent window needs 16 fresh chips.
REQ-033 Acquisition then data: 16 chips rx_din=+200 with prn_chip=1 -> corr_out=3200, corr_vld one cycle after chip 16, state 1->2, bit_vld=0. Next 16 chips rx_din=-200 with prn_chip=1 -> corr_out=-3200, bit_out=0, bit_vld=1.
REQ-034 Misalignment: alternating rx_din=+200/-200 with prn_chip=1 -> corr_out=0, prn_slip pulse with corr_vld, state stays 1, no bit_vld.
REQ-035 Lock loss: in LOCK, three windows with rx_din=0 -> bit_vld on each; state becomes 1 at the third corr_vld; locked falls on that cycle.
REQ-036 Gaps and enable: 7 chips, then rx_vld low for 5 cycles, then 9 chips -> one window completes normally. Drop en after 7 chips, re-enable -> IDLE then ACQ; 16 new chips are needed.
REQ-037 Extreme: 16 chips rx_din=-32768 with prn_chip=0 -> corr_out=+524288 with no wrap; same with prn_chip=1 -> -524288; both count as hits.
